// File: rtl/r_mc_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | r_mc_pkg : funct / ALU-op constants and sequencer state encoding        |
// | Rev 1.0                                                                  |
// +-------------------------------------------------------------------------+
package r_mc_pkg;

  localparam logic [5:0] FUNCT_ADD  = 6'b100000;
  localparam logic [5:0] FUNCT_SUB  = 6'b100010;
  localparam logic [5:0] FUNCT_AND  = 6'b100100;
  localparam logic [5:0] FUNCT_OR   = 6'b100101;
  localparam logic [5:0] FUNCT_XOR  = 6'b100110;
  localparam logic [5:0] FUNCT_NOR  = 6'b100111;
  localparam logic [5:0] FUNCT_SLTU = 6'b101011;
  localparam logic [5:0] FUNCT_SLLV = 6'b000100;

  localparam logic [2:0] ALUOP_AND  = 3'b000;
  localparam logic [2:0] ALUOP_OR   = 3'b001;
  localparam logic [2:0] ALUOP_XOR  = 3'b010;
  localparam logic [2:0] ALUOP_NOR  = 3'b011;
  localparam logic [2:0] ALUOP_ADD  = 3'b100;
  localparam logic [2:0] ALUOP_SUB  = 3'b101;
  localparam logic [2:0] ALUOP_SLTU = 3'b110;
  localparam logic [2:0] ALUOP_SLLV = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_t;

endpackage
`default_nettype wire

// File: rtl/r_funct_decode.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | r_funct_decode : R-type opcode/funct -> ALU op and legality             |
// | Rev 1.0                                                                  |
// +-------------------------------------------------------------------------+
module r_funct_decode (
  input  logic [5:0] i_opcode,
  input  logic [5:0] i_funct,
  output logic [2:0] o_alu_op,
  output logic       o_legal
);
  import r_mc_pkg::*;

  logic w_funct_ok;

  always_comb begin
    o_alu_op   = ALUOP_AND;
    w_funct_ok = 1'b1;
    case (i_funct)
      FUNCT_ADD:  o_alu_op = ALUOP_ADD;
      FUNCT_SUB:  o_alu_op = ALUOP_SUB;
      FUNCT_AND:  o_alu_op = ALUOP_AND;
      FUNCT_OR:   o_alu_op = ALUOP_OR;
      FUNCT_XOR:  o_alu_op = ALUOP_XOR;
      FUNCT_NOR:  o_alu_op = ALUOP_NOR;
      FUNCT_SLTU: o_alu_op = ALUOP_SLTU;
      FUNCT_SLLV: o_alu_op = ALUOP_SLLV;
      default:    w_funct_ok = 1'b0;
    endcase
  end

  assign o_legal = (i_opcode == 6'd0) && w_funct_ok;

endmodule
`default_nettype wire

// File: rtl/r_mc_ctrl.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | r_mc_ctrl : FETCH/DECODE/EXEC/WB sequencer for the R-type datapath      |
// | Optional flag latch / overflow breakpoint: define R_MC_FLAG_LATCH_EN    |
// | Rev 1.0                                                                  |
// +-------------------------------------------------------------------------+
module r_mc_ctrl #(
  parameter int CNT_W = 16,
  parameter int PC_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             step,
  input  logic [31:0]      inst,
  input  logic             zf,
  input  logic             of,
  output logic [PC_W-1:0]  pc,
  output logic [4:0]       rs,
  output logic [4:0]       rt,
  output logic [4:0]       rd,
  output logic [2:0]       alu_op,
  output logic             rf_we,
  output logic             busy,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
`ifdef R_MC_FLAG_LATCH_EN
  ,
  output logic             zf_q,
  output logic             of_q
`endif
);
  import r_mc_pkg::*;

  state_t           r_state;
  state_t           w_next;
  logic [PC_W-1:0]  r_pc;
  logic [31:0]      r_ir;
  logic             r_illegal;
  logic [CNT_W-1:0] r_retired;

  logic [2:0] w_ir_alu_op;
  logic       w_ir_legal_unused;
  logic [2:0] w_inst_alu_op_unused;
  logic       w_inst_legal;
  logic       w_of_brk;

  // One decoder drives alu_op from IR; the other vets the ROM word before it is latched.
  r_funct_decode u_dec_ir (
    .i_opcode (r_ir[31:26]),
    .i_funct  (r_ir[5:0]),
    .o_alu_op (w_ir_alu_op),
    .o_legal  (w_ir_legal_unused)
  );

  r_funct_decode u_dec_inst (
    .i_opcode (inst[31:26]),
    .i_funct  (inst[5:0]),
    .o_alu_op (w_inst_alu_op_unused),
    .o_legal  (w_inst_legal)
  );

`ifdef R_MC_FLAG_LATCH_EN
  logic r_zf_q;
  logic r_of_q;
  logic w_of_ld;

  assign w_of_ld  = ((w_ir_alu_op == ALUOP_ADD) || (w_ir_alu_op == ALUOP_SUB)) ? of : 1'b0;
  assign w_of_brk = w_of_ld;
  assign zf_q     = r_zf_q;
  assign of_q     = r_of_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_zf_q <= 1'b0;
      r_of_q <= 1'b0;
    end else if (r_state == ST_WB) begin
      r_zf_q <= zf;
      r_of_q <= w_of_ld;
    end
  end
`else
  logic w_flags_unused;
  assign w_flags_unused = zf ^ of;
  assign w_of_brk       = 1'b0;
`endif

  logic w_ir_bits_unused;
  assign w_ir_bits_unused = ^{r_ir[10:6], w_ir_legal_unused, w_inst_alu_op_unused};

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (run || step) w_next = ST_FETCH;
      ST_FETCH:  w_next = ST_DECODE;
      ST_DECODE: w_next = w_inst_legal ? ST_EXEC : ST_HALT;
      ST_EXEC:   w_next = ST_WB;
      ST_WB:     w_next = (run && !w_of_brk) ? ST_FETCH : ST_IDLE;
      ST_HALT:   w_next = ST_HALT;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_pc      <= '0;
      r_ir      <= '0;
      r_illegal <= 1'b0;
      r_retired <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == ST_DECODE) begin
        r_ir <= inst;
        if (!w_inst_legal) r_illegal <= 1'b1;
      end
      if (r_state == ST_WB) begin
        r_pc      <= r_pc + PC_W'(4);
        r_retired <= r_retired + CNT_W'(1);
      end
    end
  end

  assign pc      = r_pc;
  assign rs      = r_ir[25:21];
  assign rt      = r_ir[20:16];
  assign rd      = r_ir[15:11];
  assign alu_op  = w_ir_alu_op;
  // Gated by rst so a reset landing on WB never commits a write.
  assign rf_we   = (r_state == ST_WB) && !rst;
  assign busy    = (r_state != ST_IDLE) && (r_state != ST_HALT);
  assign illegal = r_illegal;
  assign retired = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_r_mc_ctrl.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | tb_r_mc_ctrl : randomized bench with ROM and instruction-level model    |
// | Rev 1.0                                                                  |
// +-------------------------------------------------------------------------+
module tb_r_mc_ctrl;

  logic        clk = 1'b0;
  logic        rst, run, step, zf, of;
  logic [31:0] inst;
  logic [7:0]  pc;
  logic [4:0]  rs, rt, rd;
  logic [2:0]  alu_op;
  logic        rf_we, busy, illegal;
  logic [15:0] retired;
`ifdef R_MC_FLAG_LATCH_EN
  logic        zf_q, of_q;
`endif

  logic [31:0] rom [64];
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) inst <= rom[pc[7:2]];

  r_mc_ctrl #(.CNT_W(16), .PC_W(8)) dut (
    .clk(clk), .rst(rst), .run(run), .step(step), .inst(inst), .zf(zf), .of(of),
    .pc(pc), .rs(rs), .rt(rt), .rd(rd), .alu_op(alu_op), .rf_we(rf_we),
    .busy(busy), .illegal(illegal), .retired(retired)
`ifdef R_MC_FLAG_LATCH_EN
    , .zf_q(zf_q), .of_q(of_q)
`endif
  );

  function automatic logic [2:0] spec_op(input logic [5:0] f);
    case (f)
      6'b100000: return 3'b100;
      6'b100010: return 3'b101;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b100110: return 3'b010;
      6'b100111: return 3'b011;
      6'b101011: return 3'b110;
      6'b000100: return 3'b111;
      default:   return 3'b000;
    endcase
  endfunction

  function automatic bit spec_legal(input logic [31:0] w);
    logic [5:0] f;
    f = w[5:0];
    return (w[31:26] == 6'd0) &&
           (f == 6'b100000 || f == 6'b100010 || f == 6'b100100 || f == 6'b100101 ||
            f == 6'b100110 || f == 6'b100111 || f == 6'b101011 || f == 6'b000100);
  endfunction

  function automatic logic [31:0] rand_legal();
    logic [5:0] fl [8];
    fl = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
           6'b100110, 6'b100111, 6'b101011, 6'b000100};
    return {6'd0, 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), fl[$urandom_range(0, 7)]};
  endfunction

  function automatic logic [31:0] rand_illegal();
    logic [31:0] w;
    do w = {6'd0, 20'($urandom), 6'($urandom)}; while (spec_legal(w));
    return w;
  endfunction

  task automatic do_reset();
    @(negedge clk); rst = 1'b1; run = 1'b0; step = 1'b0;
    @(negedge clk); @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk); rst = 1'b1; run = 1'b0; step = 1'b0;
    @(negedge clk); @(negedge clk);
    n_cmp++; if (pc !== 8'd0)      begin n_err++; $display("FAIL reset_pc got %h want 00", pc); end
    n_cmp++; if (retired !== 16'd0) begin n_err++; $display("FAIL reset_retired got %0d want 0", retired); end
    n_cmp++; if ({busy, illegal, rf_we} !== 3'b000)
      begin n_err++; $display("FAIL reset_flags busy/illegal/rf_we got %b want 000", {busy, illegal, rf_we}); end
    n_cmp++; if ({alu_op, rd} !== 8'd0) begin n_err++; $display("FAIL reset_ir alu_op/rd got %b/%0d want 0/0", alu_op, rd); end
    rst = 1'b0;
  endtask

  task automatic test_add_run();
    do_reset();
    run = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      n_cmp++; if (busy !== 1'b1 || rf_we !== (k == 4))
        begin n_err++; $display("FAIL add_seq cycle %0d busy/rf_we got %b%b want 1%b", k, busy, rf_we, k == 4); end
      if (k >= 3) begin
        n_cmp++; if (alu_op !== 3'b100 || rd !== 5'd3)
          begin n_err++; $display("FAIL add_ctrl cycle %0d alu_op/rd got %b/%0d want 100/3", k, alu_op, rd); end
      end
      if (k == 4) run = 1'b0;
    end
    @(negedge clk);
    n_cmp++; if (pc !== 8'd4 || retired !== 16'd1 || busy !== 1'b0)
      begin n_err++; $display("FAIL add_done pc/retired/busy got %h/%0d/%b want 04/1/0", pc, retired, busy); end
  endtask

  task automatic test_step();
    int we_cnt = 0;
    logic [2:0] op_seen = 3'bx;
    step = 1'b1;
    @(negedge clk); step = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      step = (k == 0);
      if (rf_we) begin we_cnt++; op_seen = alu_op; end
    end
    step = 1'b0;
    n_cmp++; if (we_cnt != 1) begin n_err++; $display("FAIL step_wb_count got %0d want 1", we_cnt); end
    n_cmp++; if (op_seen !== 3'b101) begin n_err++; $display("FAIL step_alu_op got %b want 101", op_seen); end
    n_cmp++; if (pc !== 8'd8 || busy !== 1'b0 || retired !== 16'd2)
      begin n_err++; $display("FAIL step_done pc/busy/retired got %h/%b/%0d want 08/0/2", pc, busy, retired); end
  endtask

  task automatic test_run_drop();
    int we_cnt = 0;
    int drop_at;
    logic [7:0] pc0;
    pc0 = pc;
    drop_at = $urandom_range(1, 3);
    run = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == drop_at) run = 1'b0;
      if (rf_we) we_cnt++;
    end
    n_cmp++; if (we_cnt != 1 || pc !== pc0 + 8'd4 || busy !== 1'b0)
      begin n_err++; $display("FAIL run_drop wb/pc/busy got %0d/%h/%b want 1/%h/0", we_cnt, pc, busy, pc0 + 8'd4); end
  endtask

  task automatic test_illegal(input int bad_idx, input logic [31:0] bad_word);
    int we_cnt = 0;
    bit pc_moved = 0, state_bad = 0, seen = 0;
    for (int i = 0; i < bad_idx; i++) rom[i] = rand_legal();
    rom[bad_idx] = bad_word;
    do_reset();
    run = 1'b1;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      seen = (illegal === 1'b1);
    end
    n_cmp++; if (!seen) begin n_err++; $display("FAIL illegal_timeout illegal got %b want 1", illegal); end
    n_cmp++; if (pc !== 8'(4 * bad_idx) || retired !== 16'(bad_idx))
      begin n_err++; $display("FAIL illegal_halt_at pc/retired got %h/%0d want %h/%0d", pc, retired, 8'(4 * bad_idx), bad_idx); end
    for (int k = 0; k < 100; k++) begin
      step = k[0];
      @(negedge clk);
      if (rf_we) we_cnt++;
      if (pc !== 8'(4 * bad_idx)) pc_moved = 1;
      if (busy !== 1'b0 || illegal !== 1'b1) state_bad = 1;
    end
    step = 1'b0;
    n_cmp++; if (we_cnt != 0 || pc_moved || state_bad)
      begin n_err++; $display("FAIL halt_hold we/pc_moved/state_bad got %0d/%0d/%0d want 0/0/0", we_cnt, pc_moved, state_bad); end
    do_reset();
    n_cmp++; if (pc !== 8'd0 || illegal !== 1'b0)
      begin n_err++; $display("FAIL halt_rst pc/illegal got %h/%b want 00/0", pc, illegal); end
  endtask

  task automatic test_rst_wb();
    bit seen = 0;
    rom[0] = 32'h00221820;
    do_reset();
    run = 1'b1;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      seen = (rf_we === 1'b1);
    end
    n_cmp++; if (!seen) begin n_err++; $display("FAIL rstwb_timeout rf_we got %b want 1", rf_we); end
    rst = 1'b1;
    #1;
    n_cmp++; if (rf_we !== 1'b0) begin n_err++; $display("FAIL rstwb_we got %b want 0", rf_we); end
    @(negedge clk);
    n_cmp++; if (pc !== 8'd0 || retired !== 16'd0 || busy !== 1'b0)
      begin n_err++; $display("FAIL rstwb_state pc/retired/busy got %h/%0d/%b want 00/0/0", pc, retired, busy); end
    run = 1'b0; rst = 1'b0;
  endtask

  task automatic test_wrap();
    int gap;
    bit seen;
    logic [31:0] w;
    for (int i = 0; i < 64; i++) rom[i] = rand_legal();
    do_reset();
    run = 1'b1;
    for (int i = 0; i < 64; i++) begin
      gap = 0; seen = 0;
      while (!seen && gap < 8) begin
        @(negedge clk);
        gap++;
        seen = (rf_we === 1'b1);
      end
      w = rom[i];
      n_cmp++; if (!seen || gap != 4)
        begin n_err++; $display("FAIL wrap_gap instr %0d got %0d cycles want 4", i, gap); end
      n_cmp++; if (pc !== 8'(4 * i))
        begin n_err++; $display("FAIL wrap_pc instr %0d got %h want %h", i, pc, 8'(4 * i)); end
      n_cmp++; if ({rs, rt, rd, alu_op} !== {w[25:21], w[20:16], w[15:11], spec_op(w[5:0])})
        begin n_err++; $display("FAIL wrap_ctrl instr %0d rs/rt/rd/op got %0d/%0d/%0d/%b want %0d/%0d/%0d/%b",
                                i, rs, rt, rd, alu_op, w[25:21], w[20:16], w[15:11], spec_op(w[5:0])); end
      if (i == 63) run = 1'b0;
    end
    @(negedge clk);
    n_cmp++; if (pc !== 8'd0 || retired !== 16'd64 || busy !== 1'b0)
      begin n_err++; $display("FAIL wrap_end pc/retired/busy got %h/%0d/%b want 00/64/0", pc, retired, busy); end
  endtask

`ifdef R_MC_FLAG_LATCH_EN
  task automatic test_flags();
    bit seen;
    rom[0] = 32'h00221820;
    rom[1] = {6'd0, 5'd1, 5'd2, 5'd5, 5'd0, 6'b100110};
    do_reset();
    n_cmp++; if ({zf_q, of_q} !== 2'b00) begin n_err++; $display("FAIL flag_reset got %b want 00", {zf_q, of_q}); end
    zf = 1'b1; of = 1'b1; run = 1'b1;
    for (int n = 0; n < 2; n++) begin
      seen = 0;
      for (int k = 0; k < 10 && !seen; k++) begin
        @(negedge clk);
        seen = (rf_we === 1'b1);
      end
      n_cmp++; if (!seen) begin n_err++; $display("FAIL flag_timeout instr %0d", n); end
      @(negedge clk);
      n_cmp++; if ({zf_q, of_q} !== {1'b1, n == 0})
        begin n_err++; $display("FAIL flag_latch instr %0d got %b want 1%b", n, {zf_q, of_q}, n == 0); end
      n_cmp++; if (busy !== (n != 0))
        begin n_err++; $display("FAIL flag_brk instr %0d busy got %b want %b", n, busy, n != 0); end
    end
    run = 1'b0; zf = 1'b0; of = 1'b0;
  endtask
`endif

  initial begin
    rst = 1'b1; run = 1'b0; step = 1'b0; zf = 1'b0; of = 1'b0;
    for (int i = 0; i < 64; i++) rom[i] = rand_legal();
    rom[0] = 32'h00221820;
    rom[1] = 32'h00432022;
    test_reset();
    test_add_run();
    test_step();
    test_run_drop();
    test_illegal(1, 32'h08000000);
    test_illegal($urandom_range(0, 5), rand_illegal());
    test_rst_wb();
    test_wrap();
`ifdef R_MC_FLAG_LATCH_EN
    test_flags();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout compared %0d", n_cmp);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
